// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and command control bundle used by the initiator.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  // Width-independent part of a command; address and data widths are per instance.
  typedef struct packed {
    logic       write;
    logic [2:0] size;
  } ahb_ctrl_t;

  // Width-independent part of a response.
  typedef struct packed {
    logic valid;
    logic err;
  } ahb_rsp_flags_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus bundle between one initiator and one target.
interface ahb_lite_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [1:0]    htrans;
  logic          hmastlock;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic          hresp;
  logic [DW-1:0] hrdata;

  modport master (
    output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-beat command port to pipelined AHB-Lite SINGLE transfers, with
// wait-state handling and replay of the overlapped address phase after ERROR.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_DEFAULT  = 4'b0011
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AHB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic                      cmd_write,
  input  logic [2:0]                cmd_size,
  input  logic [AHB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  output logic [AHB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic [AHB_ADDR_WIDTH-1:0] haddr,
  output logic                      hwrite,
  output logic [2:0]                hsize,
  output logic [2:0]                hburst,
  output logic [3:0]                hprot,
  output logic [1:0]                htrans,
  output logic                      hmastlock,
  output logic [AHB_DATA_WIDTH-1:0] hwdata,
  input  logic                      hready,
  input  logic                      hresp,
  input  logic [AHB_DATA_WIDTH-1:0] hrdata
);

  // Address stage: haddr is its address register, a_ctrl drives hwrite/hsize.
  ahb_ctrl_t                 a_ctrl;
  logic [AHB_DATA_WIDTH-1:0] a_wdata;
  logic                      a_valid;
  logic                      a_replay;
  // Data stage.
  logic                      d_valid;
  logic                      d_write;

  logic err_first;
  logic accept;

  assign err_first = hresp && !hready;
  assign cmd_ready = (!a_valid || (hready && !err_first)) && !a_replay;
  assign accept    = cmd_valid && cmd_ready;

  assign hwrite    = a_ctrl.write;
  assign hsize     = a_ctrl.size;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_DEFAULT;
  assign hmastlock = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ctrl    <= '0;
      a_wdata   <= '0;
      a_valid   <= 1'b0;
      a_replay  <= 1'b0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      haddr     <= '0;
      htrans    <= HTRANS_IDLE;
      hwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (hready) begin
        if (d_valid) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= d_write ? '0 : hrdata;
          rsp_err   <= hresp;
        end
        d_valid <= a_valid && !a_replay;
        if (a_valid && !a_replay) begin
          d_write <= a_ctrl.write;
          hwdata  <= a_wdata;
        end
        // The IDLE of the second error cycle completes here; re-drive A next.
        if (a_replay) begin
          a_replay <= 1'b0;
          htrans   <= HTRANS_NONSEQ;
        end else begin
          a_valid <= 1'b0;
          htrans  <= HTRANS_IDLE;
        end
      end else if (err_first && d_valid && a_valid) begin
        a_replay <= 1'b1;
        htrans   <= HTRANS_IDLE;
      end
      // NOTE: the last non-blocking assignment in a block wins, so a command
      // accepted on this edge overrides the "A empties / IDLE" update above.
      if (accept) begin
        a_valid <= 1'b1;
        haddr   <= cmd_addr;
        a_ctrl  <= '{write: cmd_write, size: cmd_size};
        a_wdata <= cmd_wdata;
        htrans  <= HTRANS_NONSEQ;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: behavioural AHB memory target, bus trace
// per cycle, and an in-order response scoreboard fed at command acceptance.
module tb_ahb_lite_master;

  localparam logic [31:0] NO_ADDR  = 32'hFFFF_FFFF;
  localparam logic [31:0] ERR_ADDR = 32'h0000_1F00;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  ahb_lite_master_if #(.AW(32), .DW(32)) bus ();

  ahb_lite_master #(
    .AHB_ADDR_WIDTH(32),
    .AHB_DATA_WIDTH(32),
    .HPROT_DEFAULT (4'b0011)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_write(cmd_write),
    .cmd_size (cmd_size),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .haddr    (bus.haddr),
    .hwrite   (bus.hwrite),
    .hsize    (bus.hsize),
    .hburst   (bus.hburst),
    .hprot    (bus.hprot),
    .htrans   (bus.htrans),
    .hmastlock(bus.hmastlock),
    .hwdata   (bus.hwdata),
    .hready   (bus.hready),
    .hresp    (bus.hresp),
    .hrdata   (bus.hrdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory target ----------------
  logic [31:0] mem [256];
  logic        loaded;
  logic        dp_valid, dp_write, dp_err, err2;
  logic [31:0] dp_addr;
  logic [2:0]  dp_size;
  int          dp_wait;
  logic [31:0] wait_addr;
  int          wait_n;

  assign bus.hready = !dp_valid ? 1'b1 : (dp_err ? err2 : (dp_wait == 0));
  assign bus.hresp  = dp_valid && dp_err;
  assign bus.hrdata = (dp_valid && !dp_write) ? mem[dp_addr[9:2]] : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_err   <= 1'b0;
      err2     <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= '0;
      dp_wait  <= 0;
      if (!loaded) begin
        mem[4] <= 32'hDEAD_BEEF;
        mem[8] <= 32'h1234_5678;
        loaded <= 1'b1;
      end
    end else if (bus.hready) begin
      if (dp_valid && dp_write && !dp_err) begin
        case (dp_size)
          3'b000:  mem[dp_addr[9:2]][{dp_addr[1:0], 3'b000} +: 8] <= bus.hwdata[{dp_addr[1:0], 3'b000} +: 8];
          3'b001:  mem[dp_addr[9:2]][{dp_addr[1], 4'b0000} +: 16] <= bus.hwdata[{dp_addr[1], 4'b0000} +: 16];
          default: mem[dp_addr[9:2]] <= bus.hwdata;
        endcase
      end
      dp_valid <= bus.htrans[1];
      if (bus.htrans[1]) begin
        dp_addr  <= bus.haddr;
        dp_write <= bus.hwrite;
        dp_size  <= bus.hsize;
        dp_err   <= (bus.haddr == ERR_ADDR);
        err2     <= 1'b0;
        dp_wait  <= (bus.haddr == wait_addr) ? wait_n : 0;
      end
    end else if (dp_err) begin
      err2 <= 1'b1;
    end else begin
      dp_wait <= dp_wait - 1;
    end
  end

  // ---------------- checking infrastructure ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  tr_htrans [1024];
  logic [31:0] tr_haddr  [1024];
  logic [31:0] tr_hwdata [1024];
  logic [2:0]  tr_hsize  [1024];
  logic        tr_rsp    [1024];

  function automatic int ix(input int k);
    return k & 1023;
  endfunction

  always @(negedge clk) begin
    tr_htrans[ix(cyc)] <= bus.htrans;
    tr_haddr[ix(cyc)]  <= bus.haddr;
    tr_hwdata[ix(cyc)] <= bus.hwdata;
    tr_hsize[ix(cyc)]  <= bus.hsize;
    tr_rsp[ix(cyc)]    <= rsp_valid;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_seen     = 0;
  int   rsp_expected = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, output int c);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_size  = size;
    cmd_wdata = wdata;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
    if (n >= 100) begin
      check("cmd_ready timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.rdata = exp_rdata;
      e.err   = exp_err;
      exp_q.push_back(e);
      rsp_expected++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain timeout", exp_q.size(), 32'd0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  // ---------------- directed tests ----------------
  initial begin
    int c, c2;
    int cs[4];
    rst_n     = 1'b0;
    loaded    = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_size  = 3'b010;
    cmd_wdata = '0;
    wait_addr = NO_ADDR;
    wait_n    = 0;

    repeat (3) @(negedge clk);
    check("reset htrans", {30'd0, bus.htrans}, 32'd0);
    check("reset haddr", bus.haddr, 32'd0);
    check("reset hwdata", bus.hwdata, 32'd0);
    check("reset hprot", {28'd0, bus.hprot}, 32'd3);
    check("reset hburst", {29'd0, bus.hburst}, 32'd0);
    check("reset hmastlock", {31'd0, bus.hmastlock}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rst_n = 1'b1;

    // Single read, zero wait.
    issue(32'h10, 1'b0, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b0, c);
    idle();
    drain();
    check("t1 htrans c+1", {30'd0, tr_htrans[ix(c + 1)]}, 32'd2);
    check("t1 haddr c+1", tr_haddr[ix(c + 1)], 32'h10);
    check("t1 no rsp c+2", {31'd0, tr_rsp[ix(c + 2)]}, 32'd0);
    check("t1 rsp c+3", {31'd0, tr_rsp[ix(c + 3)]}, 32'd1);

    // Four back-to-back word writes, then read-back.
    for (int i = 0; i < 4; i++)
      issue(32'(4 * i), 1'b1, 3'b010, 32'(i + 1), 32'h0, 1'b0, cs[i]);
    idle();
    drain();
    for (int i = 0; i < 4; i++) begin
      check("t2 accept cycle", cs[i] - cs[0], i);
      check("t2 htrans", {30'd0, tr_htrans[ix(cs[0] + 1 + i)]}, 32'd2);
      check("t2 haddr", tr_haddr[ix(cs[0] + 1 + i)], 32'(4 * i));
      check("t2 hwdata", tr_hwdata[ix(cs[0] + 2 + i)], 32'(i + 1));
      check("t2 rsp", {31'd0, tr_rsp[ix(cs[0] + 3 + i)]}, 32'd1);
    end
    for (int i = 0; i < 4; i++)
      issue(32'(4 * i), 1'b0, 3'b010, 32'h0, 32'(i + 1), 1'b0, c);
    idle();
    drain();

    // Two wait states on the first of two reads.
    wait_addr = 32'h10;
    wait_n    = 2;
    issue(32'h10, 1'b0, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b0, c);
    issue(32'h4, 1'b0, 3'b010, 32'h0, 32'h2, 1'b0, c2);
    idle();
    drain();
    wait_addr = NO_ADDR;
    check("t3 b2b accept", c2 - c, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      check("t3 haddr held", tr_haddr[ix(c + k)], 32'h4);
      check("t3 htrans held", {30'd0, tr_htrans[ix(c + k)]}, 32'd2);
    end
    check("t3 idle after", {30'd0, tr_htrans[ix(c + 5)]}, 32'd0);
    check("t3 no rsp c+4", {31'd0, tr_rsp[ix(c + 4)]}, 32'd0);
    check("t3 rsp1 c+5", {31'd0, tr_rsp[ix(c + 5)]}, 32'd1);
    check("t3 rsp2 c+6", {31'd0, tr_rsp[ix(c + 6)]}, 32'd1);

    // ERROR on a write while a read is in its address phase.
    issue(ERR_ADDR, 1'b1, 3'b010, 32'h5555_AAAA, 32'h0, 1'b1, c);
    issue(32'h20, 1'b0, 3'b010, 32'h0, 32'h1234_5678, 1'b0, c2);
    idle();
    drain();
    check("t4 b2b accept", c2 - c, 32'd1);
    check("t4 read nonseq", {30'd0, tr_htrans[ix(c + 2)]}, 32'd2);
    check("t4 idle 2nd err", {30'd0, tr_htrans[ix(c + 3)]}, 32'd0);
    check("t4 haddr kept", tr_haddr[ix(c + 3)], 32'h20);
    check("t4 replay nonseq", {30'd0, tr_htrans[ix(c + 4)]}, 32'd2);
    check("t4 replay haddr", tr_haddr[ix(c + 4)], 32'h20);
    check("t4 err rsp c+4", {31'd0, tr_rsp[ix(c + 4)]}, 32'd1);
    check("t4 no rsp c+5", {31'd0, tr_rsp[ix(c + 5)]}, 32'd0);
    check("t4 read rsp c+6", {31'd0, tr_rsp[ix(c + 6)]}, 32'd1);

    // Byte write into lane 3, then word read of the same word.
    issue(32'h3, 1'b1, 3'b000, 32'hAB00_0000, 32'h0, 1'b0, c);
    issue(32'h0, 1'b0, 3'b010, 32'h0, 32'hAB00_0001, 1'b0, c2);
    idle();
    drain();
    check("t5 byte hsize", {29'd0, tr_hsize[ix(c + 1)]}, 32'd0);
    check("t5 byte haddr", tr_haddr[ix(c + 1)], 32'h3);
    check("t5 word hsize", {29'd0, tr_hsize[ix(c2 + 1)]}, 32'd2);

    // Reset during a stalled data phase with a second command in A.
    wait_addr = 32'h10;
    wait_n    = 5;
    issue(32'h10, 1'b0, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b0, c);
    issue(32'h4, 1'b0, 3'b010, 32'h0, 32'h2, 1'b0, c2);
    idle();
    check("t6 stalled", {31'd0, bus.hready}, 32'd0);
    check("t6 pre htrans", {30'd0, bus.htrans}, 32'd2);
    rst_n = 1'b0;
    exp_q.delete();
    rsp_expected -= 2;
    #1;
    check("t6 rst htrans", {30'd0, bus.htrans}, 32'd0);
    check("t6 rst haddr", bus.haddr, 32'd0);
    check("t6 rst hwrite", {31'd0, bus.hwrite}, 32'd0);
    check("t6 rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t6 rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    wait_addr = NO_ADDR;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(32'h8, 1'b0, 3'b010, 32'h0, 32'h3, 1'b0, c);
    idle();
    drain();
    check("t6 post htrans", {30'd0, tr_htrans[ix(c + 1)]}, 32'd2);
    check("t6 post rsp c+3", {31'd0, tr_rsp[ix(c + 3)]}, 32'd1);

    repeat (5) @(negedge clk);
    check("rsp count", rsp_seen, rsp_expected);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

AHB-Lite initiator that turns single-beat commands from a simple valid/ready request port into pipelined AHB-Lite SINGLE transfers. It drives the master side of an `AHB_BUS` (feeding `ahb_node_wrap`) and returns one response per command. It handles slave wait states, two-cycle ERROR responses with replay of the overlapped address phase, and back-to-back issue at one transfer per cycle.

## Interface
- `AHB_ADDR_WIDTH`, default 32: haddr / cmd_addr width.
- `AHB_DATA_WIDTH`, default 32: hwdata / hrdata / cmd_wdata / rsp_rdata width.
- `HPROT_DEFAULT`, default 4'b0011: constant hprot (non-cacheable, non-bufferable, privileged, data).
- Ports, one per line:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on the edge where valid&&ready.
- `cmd_addr` in AHB_ADDR_WIDTH: byte address, already aligned to cmd_size.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_size` in 3: hsize encoding; only byte, half and word are legal.
- `cmd_wdata` in AHB_DATA_WIDTH: write data, already lane-placed by the caller.
- `rsp_valid` out 1: one-cycle pulse per completed command. There is no backpressure.
- `rsp_rdata` out AHB_DATA_WIDTH: captured hrdata. 0 for writes.
- `rsp_err` out 1: slave returned ERROR.
- `haddr` out AHB_ADDR_WIDTH; `hwrite` out 1; `hsize` out 3; `hburst` out 3; `hprot` out 4; `htrans` out 2; `hmastlock` out 1; `hwdata` out AHB_DATA_WIDTH.
- `hready` in 1; `hresp` in 1; `hrdata` in AHB_DATA_WIDTH.

## Operation
- The block has two registered stages:
  - The address stage (A) holds the command currently driven on haddr/htrans.
  - The data stage (D) holds the in-flight data phase: write flag and hwdata.
- `cmd_ready = !A.valid || (hready && !err_first)`, where err_first = hresp && !hready.
- On accept, A loads the command and htrans = NONSEQ is driven.
- A with no new command means htrans = IDLE.
- A address phase completes on an edge with hready=1:
  - A moves to D.
  - hwdata is registered from A's wdata.
  - A reloads from cmd when accepted on the same edge; otherwise A empties.
- D completes on an edge with hready=1:
  - The next cycle gives rsp_valid=1.
  - rsp_rdata = hrdata for reads, 0 for writes.
  - rsp_err = hresp.
- ERROR (hresp=1 with hready=0 while D valid):
  - At that edge, if A is valid, A is marked replay and htrans is driven IDLE for the second error cycle.
  - haddr and control stay at A's values.
  - The error response is reported normally, with rsp_err=1.
  - The IDLE completes with the second error cycle.
  - The next cycle re-drives A as NONSEQ.
  - cmd_ready=0 while replay is pending.
- `hburst` = SINGLE (3'b000), `hmastlock` = 0 and `hprot` = HPROT_DEFAULT at all times.
- BUSY and SEQ are never issued.
- No alignment or size checking is done; illegal commands are the caller's fault.
- Reset values:
  - htrans IDLE; haddr 0; hwrite 0; hsize 0; hburst 0; hprot HPROT_DEFAULT; hmastlock 0; hwdata 0.
  - rsp_valid 0; rsp_rdata 0; rsp_err 0.
  - cmd_ready 1; A and D empty; replay cleared.
- Reset asserted mid-transfer drops A and D immediately. No response is produced for in-flight commands.

## Timing
- Zero wait states: accept at edge 0 → address phase in cycle 1 → data phase in cycle 2 (hwdata valid) → rsp_valid in cycle 3. Read latency is 3 cycles.
- Throughput is one command per cycle with continuous cmd_valid and hready=1.
- Each wait cycle (hready=0) adds one cycle to both the stalled data phase and the overlapped address phase.
- haddr and control stay stable while hready=0.
- The ERROR sequence adds 1 cycle (the IDLE) before the replayed NONSEQ.
- All AHB outputs are registered. cmd_ready is the only combinational output.

## Structure
- Shared package `ahb_pkg`:
  - htrans enum: IDLE 2'b00, BUSY 01, NONSEQ 10, SEQ 11.
  - hburst SINGLE 3'b000.
  - hsize BYTE 000, HALF 001, WORD 010.
  - hresp OKAY 0, ERROR 1.
  - Command and response structs.
- Single module with no sub-module; the A/D stages are too small to split.
- An `ahb_lite_master_wrap` that binds the flat ports to `AHB_BUS.Master` is permitted but not part of this spec.

## Test plan
- Single read of 0x0000_0010 from a 0-wait memory preloaded with 0xDEAD_BEEF → NONSEQ in cycle 1, rsp_valid in cycle 3 with rdata 0xDEAD_BEEF, err 0.
- Four back-to-back word writes to 0x0, 0x4, 0x8, 0xC (data 1..4) → htrans NONSEQ on 4 consecutive cycles, hwdata 1..4 lagging by one cycle, 4 rsp_valid pulses; read-back returns 1..4.
- Slave inserts 2 wait states on the first of two reads → haddr of the second read held 3 cycles, responses in order, no extra responses.
- ERROR on a write at 0x1F00 while a read of 0x20 is in the address phase → htrans IDLE in the second error cycle, rsp_err=1 for the write, read re-issued as NONSEQ and completes OKAY.
- Byte write of 0xAB at 0x3 followed by a word read of 0x0 → hsize 000 then 010, and the read returns the byte in bits 31:24.
- rst_n asserted during a stalled data phase → outputs take reset values immediately, no rsp_valid, and the first command after release completes normally.
